output_stream_serializer: RTL
=============================

OUTPUT_STREAM_SERIALIZER -- requirements
Module: output_stream_serializer

Interface
REQ-001 SHALL have parameter INPUT_ITEM_SIZE, default 32: engine item width in bits; multiple of 8.
REQ-002 SHALL have parameter BW_IN, default 128: input stream data width; multiple of 32.
REQ-003 SHALL have parameter BW_OUT, default 32: output stream data width; multiple of 32, BW_OUT <= BW_IN.
REQ-004 SHALL have parameter DEPTH, default 2: number of BW_IN buffer slots; power of two, >= 1.
REQ-005 SHALL have parameter MSB_FIRST, default 1: 1 emits the most significant BW_OUT chunk first, 0 emits the least significant chunk first.
REQ-006 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_ni  in  1  reset; one clock, asynchronous, active-low.
REQ-008 SHALL have port clear_i  in  1  synchronous flush.
REQ-009 SHALL have port flags_sink_i  in  hci_streamer_flags_t  sink streamer flags; uses ready_start only.
REQ-010 SHALL have port stream_i  hwpe_stream_intf_stream.sink  BW_IN  engine output words.
REQ-011 SHALL have port stream_o  hwpe_stream_intf_stream.source  BW_OUT  serialized beats to the sink streamer.
REQ-012 SHALL have port busy_o  out  1  high while any slot is occupied.

Function
REQ-013 SHALL define N_BEATS = ceil(BW_IN/BW_OUT) beats per package; the package is zero-extended to N_BEATS*BW_OUT bits.
REQ-014 SHALL assert stream_i.ready iff occ_cnt < DEPTH; combinational, no dependence on stream_i.valid.
REQ-015 SHALL write stream_i.data into slot wr_ptr on stream_i handshake, increment wr_ptr modulo DEPTH, and capture with zero-cycle bubble.
REQ-016 SHALL drive stream_o.valid when occ_cnt > 0 and, for beat 0 only, flags_sink_i.ready_start = 1; beats 1..N_BEATS-1 do not check ready_start.
REQ-017 SHALL drive beat k of slot rd_ptr: MSB_FIRST=1 -> package bits [(N_BEATS-k)*BW_OUT-1 -: BW_OUT]; MSB_FIRST=0 -> bits [(k+1)*BW_OUT-1 -: BW_OUT].
REQ-018 SHALL drive stream_o.strb all-ones except on the beat carrying zero padding, where only bytes holding bits < BW_IN are set.
REQ-019 SHALL hold stream_o.data/strb stable while stream_o.valid=1 and stream_o.ready=0.
REQ-020 SHALL increment beat_cnt on each stream_o handshake; on handshake of beat N_BEATS-1 SHALL reset beat_cnt to 0, free the slot, and increment rd_ptr modulo DEPTH.
REQ-021 SHALL, on same-cycle input write and slot free, leave occ_cnt unchanged; write alone +1, free alone -1.
REQ-022 SHALL allow write into a slot freed in the same cycle only when occ_cnt was < DEPTH before the cycle; no combinational ready path from stream_o.ready to stream_i.ready.
REQ-023 SHALL, when N_BEATS = 1, emit one beat per package with ready_start gating.
REQ-024 SHALL drive stream_o.data to 0 when stream_o.valid = 0.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously clear slots, wr_ptr, rd_ptr, occ_cnt, beat_cnt to 0; stream_o.valid=0, stream_i.ready=1 after release, busy_o=0.
REQ-026 SHALL, on clear_i high, apply the same values synchronously, dropping any partially sent package; clear_i dominates simultaneous handshakes.

Structure
REQ-027 SHALL compute N_BEATS, pointer widths and the padded-byte count as localparams; no new typedefs; hci_streamer_flags_t comes from hci_package.
REQ-028 SHALL contain no sub-module; slot storage is a flat register array inside this module.

Verification
REQ-029 SHALL test: BW_IN=128, BW_OUT=32, MSB_FIRST=1, input 0x00000004_00000003_00000002_00000001, ready_start=1, ready=1 -> beats 0x4,0x3,0x2,0x1 on 4 consecutive cycles, strb=0xF.
REQ-030 SHALL test: same input with MSB_FIRST=0 -> beats 0x1,0x2,0x3,0x4.
REQ-031 SHALL test: BW_IN=96, BW_OUT=64, MSB_FIRST=0 -> 2 beats, beat 1 strb=0x0F, upper 32 bits 0.
REQ-032 SHALL test: DEPTH=2, 3 back-to-back inputs, stream_o.ready=0 -> stream_i.ready drops after 2 accepts; after 1 full package drains, the third input is accepted the next cycle.
REQ-033 SHALL test: ready_start=0 with occ_cnt=1 -> valid stays 0; ready_start raised -> beat 0 valid the same cycle; ready_start dropped mid-package -> beats 1..3 still sent.
REQ-034 SHALL test: clear_i pulse after 2 of 4 beats -> next cycle valid=0, busy_o=0, and the next input package starts at beat 0.

Source files
------------

// File: rtl/output_stream_serializer_pkg.sv
// Shared types and helpers for the output stream serializer.
package output_stream_serializer_pkg;

    // Sink streamer flags; the serializer only looks at ready_start.
    typedef struct packed {
        logic ready_start;
    } hci_streamer_flags_t;

    // Integer ceiling division, used for elaboration-time beat counts.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream interface with per-byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/output_stream_serializer.sv
// Buffers wide engine words in DEPTH slots and replays each one as
// N_BEATS narrow beats towards the sink streamer.
module output_stream_serializer
    import output_stream_serializer_pkg::*;
#(
    parameter int unsigned INPUT_ITEM_SIZE = 32,
    parameter int unsigned BW_IN           = 128,
    parameter int unsigned BW_OUT          = 32,
    parameter int unsigned DEPTH           = 2,
    parameter bit          MSB_FIRST       = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  hci_streamer_flags_t    flags_sink_i,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o,
    output logic                   busy_o
);

    localparam int unsigned N_BEATS   = ceil_div(BW_IN, BW_OUT);
    localparam int unsigned PAD_W     = N_BEATS * BW_OUT;
    localparam int unsigned PAD_BYTES = (PAD_W - BW_IN) / 8;
    localparam int unsigned STRB_W    = BW_OUT / 8;
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [STRB_W-1:0] LAST_STRB = {STRB_W{1'b1}} >> PAD_BYTES;

    // Parameter sanity: a configuration landing here is not supported.
    if (((INPUT_ITEM_SIZE % 8) != 0) || ((BW_IN % 32) != 0) || ((BW_OUT % 32) != 0) ||
        (BW_OUT > BW_IN) || (DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_invalid_params
    end

    logic [BW_IN-1:0]               r_slots [DEPTH];
    logic [PTR_W-1:0]               r_wr_ptr;
    logic [PTR_W-1:0]               r_rd_ptr;
    logic [CNT_W-1:0]               r_occ_cnt;
    logic [BEAT_W-1:0]              r_beat_cnt;

    logic                           w_in_ready;
    logic                           w_out_valid;
    logic                           w_in_hs;
    logic                           w_out_hs;
    logic                           w_last_beat;
    logic                           w_last_chunk;
    logic                           w_free;
    logic [PTR_W-1:0]               w_wr_ptr_nxt;
    logic [PTR_W-1:0]               w_rd_ptr_nxt;
    logic [BEAT_W-1:0]              w_chunk_idx;
    logic [PAD_W-1:0]               w_padded;
    logic [N_BEATS-1:0][BW_OUT-1:0] w_chunks;

    // Input side accepts whenever a slot is free, independent of the output side.
    assign w_in_ready   = (r_occ_cnt < CNT_W'(DEPTH));
    assign w_in_hs      = stream_i.valid & w_in_ready;

    // Only the first beat of a package waits for the sink streamer to be started.
    assign w_out_valid  = (r_occ_cnt != '0) && ((r_beat_cnt != '0) || flags_sink_i.ready_start);
    assign w_out_hs     = w_out_valid & stream_o.ready;
    assign w_last_beat  = (r_beat_cnt == BEAT_W'(N_BEATS - 1));
    assign w_free       = w_out_hs & w_last_beat;

    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    // The package is zero-extended and cut into BW_OUT chunks; beat order picks the chunk.
    assign w_padded     = PAD_W'(r_slots[r_rd_ptr]);
    assign w_chunks     = w_padded;
    assign w_chunk_idx  = MSB_FIRST ? (BEAT_W'(N_BEATS - 1) - r_beat_cnt) : r_beat_cnt;
    assign w_last_chunk = (w_chunk_idx == BEAT_W'(N_BEATS - 1));

    assign stream_i.ready = w_in_ready;
    assign stream_o.valid = w_out_valid;
    assign stream_o.data  = w_out_valid ? w_chunks[w_chunk_idx] : '0;
    assign stream_o.strb  = w_last_chunk ? LAST_STRB : {STRB_W{1'b1}};
    assign busy_o         = (r_occ_cnt != '0);

    // Slot storage, pointers and counters; clear_i flushes everything and wins over handshakes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_in_hs) begin
                r_slots[r_wr_ptr] <= stream_i.data;
                r_wr_ptr          <= w_wr_ptr_nxt;
            end
            if (w_out_hs) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BEAT_W'(1);
            end
            if (w_free) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_in_hs, w_free})
                2'b10:   r_occ_cnt <= r_occ_cnt + CNT_W'(1);
                2'b01:   r_occ_cnt <= r_occ_cnt - CNT_W'(1);
                default: r_occ_cnt <= r_occ_cnt;
            endcase
        end
    end

endmodule
